ble_at_cmd_streamer: RTL and testbench

//  Parametrised successor to the fixed 144-bit BLE AT-command encoder. Builds BLE UART
//  AT commands ("AT+BLEUARTTX=<payload>\r", "AT+BLEUARTRX\r") with variable payload length.

---
 rtl/ble_at_cmd_streamer.sv | 150 +++++++++++++++
 tb/tb_ble_at_cmd_streamer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ble_at_cmd_streamer.sv
// BLE UART AT-command streamer: builds "AT+BLEUARTTX=<payload>\r" / "AT+BLEUARTRX\r"
// and emits it one byte at a time over a valid/ready byte interface.
module ble_at_cmd_streamer #(
    parameter int MAX_PAYLOAD = 16,
    parameter int LEN_W       = $clog2(MAX_PAYLOAD + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               cmd_sel,
    input  logic [8*MAX_PAYLOAD-1:0] payload,
    input  logic [LEN_W-1:0]         payload_len,
    output logic                     busy,
    output logic [7:0]               out_byte,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     done,
    output logic                     err
);
    // Index must reach 12 (last TX prefix byte) and MAX_PAYLOAD-1.
    localparam int IDX_W = (LEN_W > 4) ? LEN_W : 4;

    typedef enum logic [2:0] {IDLE, PREFIX, PAYLOAD, TERM, FIN} state_t;

    state_t                   state_reg;
    logic                     is_rx_reg;
    logic [8*MAX_PAYLOAD-1:0] payload_reg;
    logic [IDX_W-1:0]         len_reg;
    logic [IDX_W-1:0]         idx_reg;

    logic [IDX_W-1:0] idx_inc;
    logic             req_ok;
    logic             xfer;
    logic             prefix_end;
    logic             payload_end;

    // Shared "AT+BLEUART" stem, then "TX=" or "RX" selected by the command.
    function automatic logic [7:0] prefix_byte(input logic rx, input logic [IDX_W-1:0] i);
        logic [7:0] b;
        case (int'(i))
            0:       b = 8'h41;
            1:       b = 8'h54;
            2:       b = 8'h2B;
            3:       b = 8'h42;
            4:       b = 8'h4C;
            5:       b = 8'h45;
            6:       b = 8'h55;
            7:       b = 8'h41;
            8:       b = 8'h52;
            9:       b = 8'h54;
            10:      b = rx ? 8'h52 : 8'h54;
            11:      b = 8'h58;
            12:      b = 8'h3D;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_comb begin
        idx_inc     = idx_reg + IDX_W'(1);
        req_ok      = (cmd_sel == 4'h2) ||
                      ((cmd_sel == 4'h1) && (payload_len <= LEN_W'(MAX_PAYLOAD)));
        xfer        = out_valid & out_ready;
        prefix_end  = (idx_reg == (is_rx_reg ? IDX_W'(11) : IDX_W'(12)));
        payload_end = (idx_inc == len_reg);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            is_rx_reg   <= 1'b0;
            payload_reg <= '0;
            len_reg     <= '0;
            idx_reg     <= '0;
            busy        <= 1'b0;
            out_byte    <= 8'h00;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (req_ok) begin
                            is_rx_reg   <= (cmd_sel == 4'h2);
                            payload_reg <= payload;
                            len_reg     <= IDX_W'(payload_len);
                            idx_reg     <= '0;
                            busy        <= 1'b1;
                            out_valid   <= 1'b1;
                            out_byte    <= 8'h41;
                            out_last    <= 1'b0;
                            state_reg   <= PREFIX;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                PREFIX: begin
                    if (xfer) begin
                        if (!prefix_end) begin
                            idx_reg  <= idx_inc;
                            out_byte <= prefix_byte(is_rx_reg, idx_inc);
                        end else if (!is_rx_reg && (len_reg != '0)) begin
                            idx_reg   <= '0;
                            out_byte  <= payload_reg[7:0];
                            state_reg <= PAYLOAD;
                        end else begin
                            out_byte  <= 8'h0D;
                            out_last  <= 1'b1;
                            state_reg <= TERM;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        if (!payload_end) begin
                            idx_reg  <= idx_inc;
                            out_byte <= payload_reg[{idx_inc, 3'b000} +: 8];
                        end else begin
                            out_byte  <= 8'h0D;
                            out_last  <= 1'b1;
                            state_reg <= TERM;
                        end
                    end
                end
                TERM: begin
                    if (xfer) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        out_byte  <= 8'h00;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state_reg <= FIN;
                    end
                end
                FIN: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ble_at_cmd_streamer.sv
// Directed bench for ble_at_cmd_streamer: full TX/RX commands, backpressure,
// rejected requests and an asynchronous reset in the middle of a payload.
module tb_ble_at_cmd_streamer;
    localparam int MAXP = 16;
    localparam int LW   = $clog2(MAXP + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              out_ready = 1'b1;
    logic [3:0]        cmd_sel = 4'h0;
    logic [8*MAXP-1:0] payload = '0;
    logic [LW-1:0]     payload_len = '0;
    logic              busy, out_valid, out_last, done, err;
    logic [7:0]        out_byte;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ble_at_cmd_streamer #(.MAX_PAYLOAD(MAXP)) dut (
        .clk(clk), .reset(reset), .start(start), .cmd_sel(cmd_sel),
        .payload(payload), .payload_len(payload_len), .busy(busy),
        .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done), .err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input bit rx, input int len,
                                            input logic [8*MAXP-1:0] pl, input int i);
        string pre;
        if (rx) pre = "AT+BLEUARTRX";
        else    pre = "AT+BLEUARTTX=";
        if (i < pre.len()) return pre[i];
        if (!rx && i < pre.len() + len) return pl[8*(i - pre.len()) +: 8];
        return 8'h0D;
    endfunction

    // Called and returns on a falling edge.
    task automatic start_cmd(input logic [3:0] cmd, input int len, input logic [8*MAXP-1:0] pl);
        cmd_sel     = cmd;
        payload_len = LW'(len);
        payload     = pl;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
    endtask

    task automatic run_cmd(input bit rx, input int len, input logic [8*MAXP-1:0] pl,
                           input bit toggle, input bit junk);
        int total;
        int i = 0;
        int cyc = 0;
        bit hold = 0;
        logic [7:0] hb = 8'h00;
        logic hl = 1'b0;
        total = rx ? 13 : 14 + len;
        check("err_quiet", 32'(err), 32'd0);
        while (i < total && cyc < 400) begin
            out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            check("busy", 32'(busy), 32'd1);
            check("valid_high", 32'(out_valid), 32'd1);
            if (hold) begin
                check("hold_byte", 32'(out_byte), 32'(hb));
                check("hold_last", 32'(out_last), 32'(hl));
            end
            if (out_ready) begin
                check($sformatf("byte%0d", i), 32'(out_byte), 32'(exp_byte(rx, len, pl, i)));
                check($sformatf("last%0d", i), 32'(out_last), 32'(i == total - 1));
                i++;
                hold = 0;
            end else begin
                hb   = out_byte;
                hl   = out_last;
                hold = 1;
            end
            if (junk) begin
                start   = (cyc % 3 == 1);
                cmd_sel = (cyc % 2 == 0) ? 4'h2 : 4'h1;
                payload = ~payload;
            end
            @(negedge clk);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("byte_count", 32'(i), 32'(total));
        check("done_fin", 32'(done), 32'd1);
        check("busy_fin", 32'(busy), 32'd0);
        check("valid_fin", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'd0);
        check("valid_idle", 32'(out_valid), 32'd0);
        $display("[TB] cmd %s len=%0d: %0d bytes in %0d cycles", rx ? "RX" : "TX", len, i, cyc);
    endtask

    task automatic bad_req(input logic [3:0] cmd, input int len, input string tag);
        start_cmd(cmd, len, '0);
        check({tag, "_err"}, 32'(err), 32'd1);
        check({tag, "_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({tag, "_err_pulse"}, 32'(err), 32'd0);
        check({tag, "_valid2"}, 32'(out_valid), 32'd0);
        $display("[TB] rejected request cmd=%0h len=%0d", cmd, len);
    endtask

    initial begin
        logic [8*MAXP-1:0] abcd;
        logic [8*MAXP-1:0] full;
        abcd = '0;
        abcd[31:0] = 32'h44434241;
        full = 128'h7A6B5C4D3E2F10F1E2D3C4B5A6978869;

        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_byte", 32'(out_byte), 32'd0);
        check("rst_last", 32'(out_last), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        start_cmd(4'h1, 4, abcd);
        run_cmd(1'b0, 4, abcd, 1'b0, 1'b0);

        // RX ignores payload_len, even one above the TX limit.
        start_cmd(4'h2, MAXP + 1, full);
        run_cmd(1'b1, 0, full, 1'b0, 1'b0);

        start_cmd(4'h1, 0, full);
        run_cmd(1'b0, 0, full, 1'b0, 1'b0);

        start_cmd(4'h1, MAXP, full);
        run_cmd(1'b0, MAXP, full, 1'b1, 1'b1);

        bad_req(4'h5, 4, "bad_cmd");
        bad_req(4'h1, MAXP + 1, "bad_len");

        start_cmd(4'h1, 4, abcd);
        repeat (15) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_byte", 32'(out_byte), 32'h43);
        #2 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_byte", 32'(out_byte), 32'd0);
        check("arst_last", 32'(out_last), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        $display("[TB] reset asserted during payload");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        start_cmd(4'h1, 4, abcd);
        run_cmd(1'b0, 4, abcd, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
